// File: rtl/clknrst_seq_ctrl.sv
// Reset / clock-enable sequencer: synchronizes reset release, holds all domains in reset
// with clocks running, releases them one by one in ascending order, and re-runs the
// sequence on a four-phase software request.
module clknrst_seq_ctrl #(
   parameter int unsigned NUM_DOMAINS = 4,
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned STAGE_GAP   = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   sw_rst_req,
   output logic                   sw_rst_ack,
   output logic [NUM_DOMAINS-1:0] rst_n_out,
   output logic [NUM_DOMAINS-1:0] clk_en,
   output logic                   busy,
   output logic [2:0]             state
);

   localparam int unsigned MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
   localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
   localparam int unsigned IDX_W   = $clog2(NUM_DOMAINS + 1);
   // The state register acts as the final synchronizer stage, so only SYNC_STAGES-1
   // dedicated flops precede it.
   localparam int unsigned FRONT_W = SYNC_STAGES - 1;

   localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GapLast  = CNT_W'(STAGE_GAP - 1);
   localparam logic [IDX_W-1:0] IdxLast  = IDX_W'(NUM_DOMAINS - 1);

   localparam logic [2:0] StRst     = 3'd0;
   localparam logic [2:0] StHold    = 3'd1;
   localparam logic [2:0] StRelease = 3'd2;
   localparam logic [2:0] StRun     = 3'd3;
   localparam logic [2:0] StDrain   = 3'd4;

   logic [FRONT_W-1:0]     sync_q;
   logic                   rst_sync;
   logic [2:0]             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
   logic [NUM_DOMAINS-1:0] clk_en_q, clk_en_d;
   logic                   ack_q, ack_d;
   logic                   sw_seq_q, sw_seq_d;
   logic                   busy_q, busy_d;

   assign rst_sync = sync_q[FRONT_W-1];

   // Reset synchronizer: asynchronous assertion, synchronous deassertion.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= (sync_q << 1) | FRONT_W'(1);
      end
   end

   // Next-state logic for the sequencing FSM, counters and outputs.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      rst_n_d  = rst_n_q;
      clk_en_d = clk_en_q;
      ack_d    = ack_q;
      sw_seq_d = sw_seq_q;

      // Four-phase completion: ack drops once the request is withdrawn.
      if (ack_q && !sw_rst_req) begin
         ack_d = 1'b0;
      end

      case (state_q)
         StRst: begin
            if (rst_sync) begin
               state_d  = StHold;
               clk_en_d = '1;
               cnt_d    = '0;
               idx_d    = '0;
            end
         end
         StHold: begin
            if (cnt_q == HoldLast) begin
               state_d    = StRelease;
               rst_n_d    = NUM_DOMAINS'(1);
               cnt_d      = '0;
               idx_d      = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StRelease: begin
            // idx_q is the highest domain already released.
            if (idx_q == IdxLast) begin
               state_d  = StRun;
               cnt_d    = '0;
               idx_d    = '0;
               ack_d    = sw_seq_q;
               sw_seq_d = 1'b0;
            end else if (cnt_q == GapLast) begin
               rst_n_d = (rst_n_q << 1) | NUM_DOMAINS'(1);
               idx_d   = idx_q + IDX_W'(1);
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StRun: begin
            if (sw_rst_req && !ack_q) begin
               state_d  = StDrain;
               rst_n_d  = rst_n_q >> 1;
               sw_seq_d = 1'b1;
               cnt_d    = '0;
               idx_d    = '0;
            end
         end
         StDrain: begin
            if (rst_n_q == '0) begin
               state_d = StHold;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               rst_n_d = rst_n_q >> 1;
            end
         end
         default: begin
            state_d = StRst;
         end
      endcase

      busy_d = (state_d != StRun);
   end

   // State and registered outputs; all forced to reset values while reset_n is low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StRst;
         cnt_q    <= '0;
         idx_q    <= '0;
         rst_n_q  <= '0;
         clk_en_q <= '0;
         ack_q    <= 1'b0;
         sw_seq_q <= 1'b0;
         busy_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         rst_n_q  <= rst_n_d;
         clk_en_q <= clk_en_d;
         ack_q    <= ack_d;
         sw_seq_q <= sw_seq_d;
         busy_q   <= busy_d;
      end
   end

   assign state      = state_q;
   assign rst_n_out  = rst_n_q;
   assign clk_en     = clk_en_q;
   assign sw_rst_ack = ack_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_clknrst_seq_ctrl.sv
// Directed bench for clknrst_seq_ctrl: default instance plus a minimal-parameter instance.
module tb_clknrst_seq_ctrl;

   localparam int N = 4;
   localparam int H = 16;
   localparam int G = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn_a, req_a, ack_a, busy_a;
   logic [3:0] rst_a, en_a;
   logic [2:0] st_a;

   logic       rstn_b, req_b, ack_b, busy_b;
   logic [0:0] rst_b, en_b;
   logic [2:0] st_b;

   int n_checks = 0;
   int n_errors = 0;

   clknrst_seq_ctrl #(
      .NUM_DOMAINS(N), .HOLD_CYCLES(H), .STAGE_GAP(G), .SYNC_STAGES(2)
   ) u_dut_a (
      .clk(clk), .reset_n(rstn_a), .sw_rst_req(req_a), .sw_rst_ack(ack_a),
      .rst_n_out(rst_a), .clk_en(en_a), .busy(busy_a), .state(st_a)
   );

   clknrst_seq_ctrl #(
      .NUM_DOMAINS(1), .HOLD_CYCLES(1), .STAGE_GAP(1), .SYNC_STAGES(2)
   ) u_dut_b (
      .clk(clk), .reset_n(rstn_b), .sw_rst_req(req_b), .sw_rst_ack(ack_b),
      .rst_n_out(rst_b), .clk_en(en_b), .busy(busy_b), .state(st_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected power-on release pattern at edge e after E0.
   function automatic logic [3:0] exp_rst(input int e);
      logic [3:0] r;
      r = '0;
      for (int k = 0; k < N; k++) if (e >= H + k * G) r[k] = 1'b1;
      return r;
   endfunction

   function automatic logic [2:0] exp_st(input int e);
      if (e < H) return 3'd1;
      if (e <= H + (N - 1) * G) return 3'd2;
      return 3'd3;
   endfunction

   task automatic check_reset_a(input string tag);
      check({tag, " state"}, 32'(st_a), 32'd0);
      check({tag, " rst_n_out"}, 32'(rst_a), 32'h0);
      check({tag, " clk_en"}, 32'(en_a), 32'h0);
      check({tag, " busy"}, 32'(busy_a), 32'd1);
      check({tag, " ack"}, 32'(ack_a), 32'd0);
   endtask

   // Called just after reset_n_a rose between edges; walks E0..E(last_e).
   task automatic power_on_a(input int last_e, input bit pulse);
      tick();
      check("sync edge1 state", 32'(st_a), 32'd0);
      check("sync edge1 clk_en", 32'(en_a), 32'h0);
      tick();
      check("E0 state", 32'(st_a), 32'd1);
      check("E0 clk_en", 32'(en_a), 32'hF);
      check("E0 rst_n_out", 32'(rst_a), 32'h0);
      for (int e = 1; e <= last_e; e++) begin
         req_a = pulse && (e == 6 || e == 21);
         tick();
         req_a = 1'b0;
         check($sformatf("po E%0d state", e), 32'(st_a), 32'(exp_st(e)));
         check($sformatf("po E%0d rst_n_out", e), 32'(rst_a), 32'(exp_rst(e)));
         check($sformatf("po E%0d busy", e), 32'(busy_a), (e >= 41) ? 32'd0 : 32'd1);
         check($sformatf("po E%0d ack", e), 32'(ack_a), 32'd0);
         check($sformatf("po E%0d clk_en", e), 32'(en_a), 32'hF);
      end
   endtask

   initial begin
      rstn_a = 1'b0; req_a = 1'b0;
      rstn_b = 1'b0; req_b = 1'b0;
      repeat (5) tick();
      check_reset_a("por");

      // Power-on sequence with defaults.
      #3 rstn_a = 1'b1;
      power_on_a(41, 1'b0);

      // Asynchronous reset mid-RELEASE, then replay with requests outside RUN.
      rstn_a = 1'b0;
      repeat (5) tick();
      #3 rstn_a = 1'b1;
      power_on_a(28, 1'b0);
      #2 rstn_a = 1'b0;
      #1 check_reset_a("async mid-release");
      repeat (3) tick();
      #3 rstn_a = 1'b1;
      power_on_a(41, 1'b1);

      // Software handshake.
      req_a = 1'b1;
      tick();
      check("drain Ek state", 32'(st_a), 32'd4);
      check("drain Ek rst", 32'(rst_a), 32'h7);
      check("drain Ek busy", 32'(busy_a), 32'd1);
      tick(); check("drain Ek+1 rst", 32'(rst_a), 32'h3);
      tick(); check("drain Ek+2 rst", 32'(rst_a), 32'h1);
      tick(); check("drain Ek+3 rst", 32'(rst_a), 32'h0);
      tick();
      check("sw Ek+4 state", 32'(st_a), 32'd1);
      check("sw Ek+4 clk_en", 32'(en_a), 32'hF);
      repeat (15) tick();
      check("sw Ek+19 rst", 32'(rst_a), 32'h0);
      tick();
      check("sw Ek+20 state", 32'(st_a), 32'd2);
      check("sw Ek+20 rst", 32'(rst_a), 32'h1);
      repeat (23) tick();
      check("sw Ek+43 rst", 32'(rst_a), 32'h7);
      tick();
      check("sw Ek+44 rst", 32'(rst_a), 32'hF);
      check("sw Ek+44 ack", 32'(ack_a), 32'd0);
      tick();
      check("sw Ek+45 state", 32'(st_a), 32'd3);
      check("sw Ek+45 ack", 32'(ack_a), 32'd1);
      check("sw Ek+45 busy", 32'(busy_a), 32'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("held req %0d state", i), 32'(st_a), 32'd3);
         check($sformatf("held req %0d ack", i), 32'(ack_a), 32'd1);
      end
      req_a = 1'b0;
      tick();
      check("ack drop", 32'(ack_a), 32'd0);
      check("ack drop state", 32'(st_a), 32'd3);
      tick();
      check("idle ack", 32'(ack_a), 32'd0);
      req_a = 1'b1;
      tick();
      check("second req state", 32'(st_a), 32'd4);
      check("second req rst", 32'(rst_a), 32'h7);

      // Reset during DRAIN with request still high.
      #2 rstn_a = 1'b0;
      #1 check_reset_a("drain reset");
      tick();
      check("drain reset ack", 32'(ack_a), 32'd0);
      req_a = 1'b0;
      repeat (2) tick();
      #3 rstn_a = 1'b1;
      power_on_a(41, 1'b0);
      repeat (3) tick();
      check("post drain-reset ack", 32'(ack_a), 32'd0);
      check("post drain-reset state", 32'(st_a), 32'd3);

      // Minimal-parameter instance.
      #3 rstn_b = 1'b1;
      tick();
      check("b sync state", 32'(st_b), 32'd0);
      tick();
      check("b E0 state", 32'(st_b), 32'd1);
      check("b E0 clk_en", 32'(en_b), 32'd1);
      check("b E0 rst", 32'(rst_b), 32'd0);
      tick();
      check("b E1 state", 32'(st_b), 32'd2);
      check("b E1 rst", 32'(rst_b), 32'd1);
      tick();
      check("b E2 state", 32'(st_b), 32'd3);
      check("b E2 busy", 32'(busy_b), 32'd0);
      check("b E2 ack", 32'(ack_b), 32'd0);
      req_b = 1'b1;
      tick();
      check("b drain state", 32'(st_b), 32'd4);
      check("b drain rst", 32'(rst_b), 32'd0);
      tick();
      check("b hold state", 32'(st_b), 32'd1);
      tick();
      check("b release state", 32'(st_b), 32'd2);
      check("b release rst", 32'(rst_b), 32'd1);
      tick();
      check("b run state", 32'(st_b), 32'd3);
      check("b run ack", 32'(ack_b), 32'd1);
      req_b = 1'b0;
      tick();
      check("b ack drop", 32'(ack_b), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
